// File: rtl/line_ser_pkg.sv
// Shared types and constants for the line serializer: FSM states, beat count and line offset.
package line_ser_pkg;

  localparam int unsigned BEATS         = 4;
  localparam int unsigned BEAT_IDX_W    = 2;
  localparam int unsigned LINE_OFFSET_W = 5;

  typedef logic [BEAT_IDX_W-1:0] beat_idx_t;

  typedef enum logic [2:0] {
    StIdle,
    StWrBurst,
    StRdReq,
    StRdWait,
    StDone
  } state_e;

endpackage

// File: rtl/beat_counter.sv
// Two-bit beat counter shared by write-beat sequencing and read-beat (rvalid) counting.
module beat_counter
  import line_ser_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [1:0] o_cnt,
  output logic       o_last
);

  beat_idx_t r_cnt;

  // Clear wins over increment; increment wraps naturally from the last beat to 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_last = (r_cnt == BEAT_IDX_W'(BEATS - 1));

endmodule

// File: rtl/line_serializer.sv
// Cache-line to bmem request serializer: single read command or 4-beat write burst.
// Optional LINE_SERIALIZER_WB_BUFFER_EN: early write response, burst drains in background.
module line_serializer
  import line_ser_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256,
  parameter int unsigned BEAT_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_dfp_addr,
  input  logic              i_dfp_read,
  input  logic              i_dfp_write,
  input  logic [LINE_W-1:0] i_dfp_wdata,
  output logic              o_dfp_wresp,
  output logic              o_busy,
  input  logic              i_bmem_ready,
  output logic [ADDR_W-1:0] o_bmem_addr,
  output logic              o_bmem_read,
  output logic              o_bmem_write,
  output logic [BEAT_W-1:0] o_bmem_wdata,
  input  logic              i_bmem_rvalid
);

  state_e              r_state;
  state_e              w_state_d;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_line;
  logic [1:0]          w_cnt;
  logic                w_cnt_last;
  logic                w_cnt_inc;
  logic                w_cnt_clr;
  logic                w_take;
  logic                w_accept_wr;
  logic                w_accept_rd;
  logic                w_unused_addr;

  assign w_unused_addr = ^i_dfp_addr[LINE_OFFSET_W-1:0];

  beat_counter u_beat_counter (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_cnt_inc),
    .o_cnt   (w_cnt),
    .o_last  (w_cnt_last)
  );

  always_comb begin
    w_state_d   = r_state;
    w_take      = 1'b0;
    w_accept_wr = 1'b0;
    w_accept_rd = 1'b0;
    w_cnt_inc   = 1'b0;
    w_cnt_clr   = 1'b0;
    unique case (r_state)
      StIdle: w_take = 1'b1;
      StWrBurst: begin
        if (i_bmem_ready) begin
          w_cnt_inc = 1'b1;
          if (w_cnt_last) begin
`ifdef LINE_SERIALIZER_WB_BUFFER_EN
            // Held-off requests are taken in the same cycle the last beat is accepted.
            w_take    = 1'b1;
            w_state_d = StIdle;
`else
            w_state_d = StDone;
`endif
          end
        end
      end
      StRdReq: if (i_bmem_ready) w_state_d = StRdWait;
      StRdWait: begin
        if (i_bmem_rvalid) begin
          w_cnt_inc = 1'b1;
          if (w_cnt_last) w_state_d = StDone;
        end
      end
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    // Write wins over read when both are (illegally) raised together.
    if (w_take) begin
      if (i_dfp_write) begin
        w_accept_wr = 1'b1;
        w_cnt_clr   = 1'b1;
        w_state_d   = StWrBurst;
      end else if (i_dfp_read) begin
        w_accept_rd = 1'b1;
        w_cnt_clr   = 1'b1;
        w_state_d   = StRdReq;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_line  <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_accept_wr || w_accept_rd) begin
        r_addr <= {i_dfp_addr[ADDR_W-1:LINE_OFFSET_W], LINE_OFFSET_W'(0)};
      end
      if (w_accept_wr) r_line <= i_dfp_wdata;
    end
  end

`ifdef LINE_SERIALIZER_WB_BUFFER_EN
  logic r_wresp;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_wresp <= 1'b0;
    else          r_wresp <= w_accept_wr;
  end

  assign o_dfp_wresp = r_wresp;
`else
  logic r_is_write;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                       r_is_write <= 1'b0;
    else if (w_accept_wr || w_accept_rd) r_is_write <= w_accept_wr;
  end

  assign o_dfp_wresp = (r_state == StDone) && r_is_write;
`endif

  assign o_busy       = (r_state != StIdle);
  assign o_bmem_addr  = r_addr;
  assign o_bmem_read  = (r_state == StRdReq);
  assign o_bmem_write = (r_state == StWrBurst);
  assign o_bmem_wdata = o_bmem_write ? r_line[32'(w_cnt) * BEAT_W +: BEAT_W] : '0;

  a_no_dual_request: assert property (@(posedge i_clk) disable iff (!i_rst_n)
      (r_state == StIdle) |-> !(i_dfp_read && i_dfp_write))
    else $warning("dfp_read and dfp_write both high in idle; write taken");

endmodule
